// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared state type and constants for the Wishbone SRAM controller
package wb_sram_pkg;
    typedef enum logic [2:0] {IDLE, RD, WR, WR_HOLD, TURN} state_t;
    localparam int   CNT_W = 4;
    localparam logic INACT = 1'b1;
    localparam logic ACT   = 1'b0;
endpackage

// File: rtl/sram_io_drv.sv
// sram_io_drv: SRAM data-pin tristate driver and read-capture register
module sram_io_drv
    import wb_sram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_oe,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_cap,
    output logic [DATA_W-1:0] o_dat,
    inout  wire  [DATA_W-1:0] io_dat
);
    logic [DATA_W-1:0] r_rd;

    assign io_dat = i_oe ? i_dat : {DATA_W{1'bz}};
    assign o_dat  = r_rd;

    // latch the SRAM pins on the final read cycle; holds until the next read
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rd <= '0;
        else if (i_cap) r_rd <= io_dat;
    end
endmodule

// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone pipelined slave driving an asynchronous SRAM with wait states
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter  int ADDR_W     = 20,
    parameter  int DATA_W     = 32,
    parameter  int RD_WAIT    = 2,
    parameter  int WR_WAIT    = 2,
    parameter  int TURNAROUND = 1,
    localparam int BYTES      = DATA_W / 8,
    localparam int OFS        = $clog2(BYTES)
) (
    input  logic              clk_bus,
    input  logic              rst_bus,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              ack_o,
    input  logic [31:0]       adr_i,
    input  logic              cyc_i,
    output logic              stall_o,
    output logic              err_o,
    output logic              rty_o,
    input  logic [BYTES-1:0]  sel_i,
    input  logic              stb_i,
    input  logic              we_i,
    output logic [ADDR_W-1:0] sram_adr,
    inout  wire  [DATA_W-1:0] sram_dat,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic [BYTES-1:0]  sram_be
);
    localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] CNT_WR = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] CNT_TA = CNT_W'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic [BYTES-1:0]  r_sel;
    logic              r_live, r_ack, r_err;
    logic              w_req, w_bad, w_acc, w_last, w_drive, w_cap;

    assign w_req    = (r_state == IDLE) && cyc_i && stb_i;
    assign w_bad    = ((adr_i >> (ADDR_W + OFS)) != 32'd0) || (we_i && (sel_i == '0));
    assign w_acc    = w_req && !w_bad;
    assign w_last   = (r_cnt == '0);
    assign w_cap    = (r_state == RD) && w_last;
    assign stall_o  = (r_state != IDLE);
    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign rty_o    = 1'b0;
    assign sram_adr = r_adr;

    // state register
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next-state: every access runs to completion regardless of cyc_i
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? (we_i ? WR : RD) : IDLE;
            RD:      w_next = w_last ? IDLE : RD;
            WR:      w_next = w_last ? WR_HOLD : WR;
            WR_HOLD: w_next = (TURNAROUND > 0) ? TURN : IDLE;
            TURN:    w_next = w_last ? IDLE : TURN;
            default: w_next = IDLE;
        endcase
    end

    // SRAM pin levels per state; data is only driven while oe is high
    always_comb begin
        sram_ce = (r_state == RD || r_state == WR || r_state == WR_HOLD) ? ACT : INACT;
        sram_oe = (r_state == RD) ? ACT : INACT;
        sram_we = (r_state == WR) ? ACT : INACT;
        sram_be = (r_state == RD) ? {BYTES{ACT}} :
                  (r_state == WR || r_state == WR_HOLD) ? ~r_sel : {BYTES{INACT}};
        w_drive = (r_state == WR) || (r_state == WR_HOLD);
    end

    // wait counter: sized on entry to RD/WR, reused for the turnaround gap
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) r_cnt <= '0;
        else if (w_acc) r_cnt <= we_i ? CNT_WR : CNT_RD;
        else if (r_state == WR_HOLD) r_cnt <= CNT_TA;
        else if (!w_last) r_cnt <= r_cnt - 1'b1;
    end

    // request capture; address stays stable for the whole access
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_acc) begin
            r_adr <= adr_i[ADDR_W+OFS-1:OFS];
            r_dat <= dat_i;
            r_sel <= sel_i;
        end
    end

    // r_live drops if the master abandons the cycle, suppressing the ack
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) r_live <= 1'b0;
        else if (w_acc) r_live <= 1'b1;
        else if (!cyc_i) r_live <= 1'b0;
    end

    // single-cycle ack after the last RD/WR edge, single-cycle err on reject
    always_ff @(posedge clk_bus or posedge rst_bus) begin
        if (rst_bus) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= r_live && cyc_i && w_last && (r_state == RD || r_state == WR);
            r_err <= w_req && w_bad;
        end
    end

    sram_io_drv #(.DATA_W(DATA_W)) u_io (
        .i_clk  (clk_bus),
        .i_rst  (rst_bus),
        .i_oe   (w_drive),
        .i_dat  (r_dat),
        .i_cap  (w_cap),
        .o_dat  (dat_o),
        .io_dat (sram_dat)
    );
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: scoreboard bench for wb_sram_ctrl (default and minimal-latency builds)
module tb_wb_sram_ctrl;
    typedef struct {
        logic        is_err;
        logic        has_dat;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cycle = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // default-parameter instance
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0, dat_o;
    logic [3:0]  sel = '0, be;
    logic        ack, stall, err, rty, ce, oe, wen;
    logic [19:0] sram_adr;
    wire  [31:0] sram_dat;

    wb_sram_ctrl u_dut (
        .clk_bus(clk), .rst_bus(rst), .dat_i(dat), .dat_o(dat_o), .ack_o(ack),
        .adr_i(adr), .cyc_i(cyc), .stall_o(stall), .err_o(err), .rty_o(rty),
        .sel_i(sel), .stb_i(stb), .we_i(we), .sram_adr(sram_adr), .sram_dat(sram_dat),
        .sram_ce(ce), .sram_oe(oe), .sram_we(wen), .sram_be(be)
    );

    // minimal-latency 16-bit instance
    logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0] m_adr = '0;
    logic [15:0] m_dat = '0, m_dat_o;
    logic [1:0]  m_sel = '0, m_be;
    logic        m_ack, m_stall, m_err, m_rty, m_ce, m_oe, m_wen;
    logic [7:0]  m_sadr;
    wire  [15:0] m_sdat;

    wb_sram_ctrl #(.ADDR_W(8), .DATA_W(16), .RD_WAIT(0), .WR_WAIT(0), .TURNAROUND(0)) u_min (
        .clk_bus(clk), .rst_bus(rst), .dat_i(m_dat), .dat_o(m_dat_o), .ack_o(m_ack),
        .adr_i(m_adr), .cyc_i(m_cyc), .stall_o(m_stall), .err_o(m_err), .rty_o(m_rty),
        .sel_i(m_sel), .stb_i(m_stb), .we_i(m_we), .sram_adr(m_sadr), .sram_dat(m_sdat),
        .sram_ce(m_ce), .sram_oe(m_oe), .sram_we(m_wen), .sram_be(m_be)
    );

    function automatic logic [31:0] init_w(int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h0101_0101) ^ 32'hA5A5_0F0F);
    endfunction

    function automatic logic [15:0] init_m(int i);
        return (16'(i) * 16'h0101) ^ 16'h5A3C;
    endfunction

    // asynchronous SRAM models: drive when ce/oe low, store enabled bytes when ce/we low
    logic [31:0] mem [256];
    logic [15:0] m_mem [256];
    assign sram_dat = (!ce && !oe) ? mem[sram_adr[7:0]] : 32'bz;
    assign m_sdat   = (!m_ce && !m_oe) ? m_mem[m_sadr] : 16'bz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_w(i);
        end else if (!ce && !wen) begin
            for (int i = 0; i < 4; i++) if (!be[i]) mem[sram_adr[7:0]][i*8+:8] <= sram_dat[i*8+:8];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) m_mem[i] <= init_m(i);
        end else if (!m_ce && !m_wen) begin
            for (int i = 0; i < 2; i++) if (!m_be[i]) m_mem[m_sadr][i*8+:8] <= m_sdat[i*8+:8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // reference model: expected bus response for a request presented to an idle slave
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int wd;
        wd = int'((a / 4) % 256);
        if (a >= 32'h0040_0000 || (w && s == 4'd0)) begin
            sbq.push_back('{1'b1, 1'b0, 32'd0});
        end else if (w) begin
            for (int i = 0; i < 4; i++) if (s[i]) ref_mem[wd][i*8+:8] = d[i*8+:8];
            sbq.push_back('{1'b0, 1'b0, 32'd0});
        end else begin
            sbq.push_back('{1'b0, 1'b1, ref_mem[wd]});
        end
    endtask

    // present a request, hold stb until the slave takes it; returns the accept cycle
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic trk, output int ac);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; ac = -1;
        for (int n = 0; n < 64 && ac < 0; n++) begin
            @(negedge clk);
            if (!stall) ac = cycle;
            @(posedge clk);
            #1;
        end
        stb = 1'b0;
        if (ac < 0) chk("req_timeout", 32'd1, 32'd0);
        else if (trk) model(w, a, d, s);
    endtask

    task automatic idle();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = !stall;
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic m_start(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_dat = d; m_sel = s;
        @(negedge clk);
        chk("min_accept_stall", 32'(m_stall), 32'd0);
        @(posedge clk);
        #1 m_stb = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the slave responds
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !oe) begin
            n_chk++;
            if (ce || !wen || be != 4'h0) begin
                n_fail++;
                $display("FAIL read_pins: ce=%b we=%b be=%b required 0 1 0000", ce, wen, be);
            end
        end
        if (ack || err) begin
            n_chk++;
            if (ack && err) begin
                n_fail++;
                $display("FAIL ack_err_both: ack=1 err=1 required at most one");
            end else if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: ack=%b err=%b with none outstanding", ack, err);
            end else begin
                e = sbq.pop_front();
                if (e.is_err != err) begin
                    n_fail++;
                    $display("FAIL resp_kind: err=%b required %b", err, e.is_err);
                end else if (e.has_dat && dat_o !== e.dat) begin
                    n_fail++;
                    $display("FAIL read_data: got %h expected %h", dat_o, e.dat);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ac, a0, a1, a2, a3, k;
        logic w;
        logic [31:0] a, d;
        logic [3:0] s;
        logic [15:0] mexp;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_w(i);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_adr", 32'(sram_adr), 0);
        chk("rst_pins", {28'd0, ce, oe, wen, 1'b1}, 32'hF);
        chk("rst_be", 32'(be), 32'hF);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rty", 32'(rty), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // read timing: word 4
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 1'b1, ac);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("rd_ce", 32'(ce), 0);
            chk("rd_oe", 32'(oe), 0);
            chk("rd_stall", 32'(stall), 1);
        end
        @(negedge clk);
        chk("rd_ack", 32'(ack), 1);
        chk("rd_dat", dat_o, 32'hDEADBEEF);
        chk("rd_stall_end", 32'(stall), 0);

        // write timing: byte lanes 0 and 2 of word 2
        idle();
        do_req(1'b1, 32'h8, 32'h11223344, 4'b0101, 1'b1, ac);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("wr_be", 32'(be), 32'hA);
            chk("wr_we", 32'(wen), 0);
            chk("wr_ce", 32'(ce), 0);
        end
        @(negedge clk);
        chk("hold_ack", 32'(ack), 1);
        chk("hold_we", 32'(wen), 1);
        chk("hold_ce", 32'(ce), 0);
        @(negedge clk);
        chk("turn_ce", 32'(ce), 1);
        chk("turn_stall", 32'(stall), 1);
        @(negedge clk);
        chk("turn_done", 32'(stall), 0);
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h8, 32'd0, 4'hF, 1'b1, ac);
        repeat (4) @(negedge clk);
        chk("wr_readback", dat_o, 32'hA7220D44);

        // back-to-back: read, read, write, read
        idle();
        do_req(1'b0, 32'h40, 32'd0, 4'hF, 1'b1, a0);
        do_req(1'b0, 32'h44, 32'd0, 4'h3, 1'b1, a1);
        do_req(1'b1, 32'h48, 32'hCAFE_F00D, 4'hF, 1'b1, a2);
        do_req(1'b0, 32'h48, 32'd0, 4'h0, 1'b1, a3);
        chk("b2b_rd2", 32'(a1 - a0), 32'd4);
        chk("b2b_wr", 32'(a2 - a0), 32'd8);
        chk("b2b_rd3", 32'(a3 - a0), 32'd14);

        // rejects: out-of-window address, then a write with no lanes
        idle();
        do_req(1'b0, 32'h0040_0000, 32'd0, 4'hF, 1'b1, ac);
        @(negedge clk);
        chk("err_addr", 32'(err), 1);
        chk("err_addr_stall", 32'(stall), 0);
        chk("err_addr_ce", 32'(ce), 1);
        @(negedge clk);
        chk("err_addr_pulse", 32'(err), 0);
        chk("err_addr_noack", 32'(ack), 0);
        chk("err_addr_ce2", 32'(ce), 1);
        @(posedge clk);
        #1;
        do_req(1'b1, 32'h4, 32'h5555_5555, 4'h0, 1'b1, ac);
        @(negedge clk);
        chk("err_sel", 32'(err), 1);
        chk("err_sel_pins", {30'd0, ce, wen}, 32'h3);
        @(negedge clk);
        chk("err_sel_pulse", 32'(err), 0);

        // cyc_i dropped mid-read: access completes silently
        idle();
        do_req(1'b0, 32'h20, 32'd0, 4'hF, 1'b0, ac);
        @(negedge clk);
        chk("drop_c1_ce", 32'(ce), 0);
        @(posedge clk);
        #1 cyc = 1'b0;
        @(negedge clk);
        chk("drop_c2_ce", 32'(ce), 0);
        @(negedge clk);
        chk("drop_c3_oe", 32'(oe), 0);
        @(negedge clk);
        chk("drop_noack", 32'(ack), 0);
        chk("drop_ce", 32'(ce), 1);
        chk("drop_idle", 32'(stall), 0);

        // zero-wait 16-bit instance
        @(posedge clk);
        #1;
        m_start(1'b0, 32'h6, 16'd0, 2'b00);
        @(negedge clk);
        chk("min_rd_pins", {30'd0, m_ce, m_oe}, 0);
        chk("min_rd_stall", 32'(m_stall), 1);
        @(negedge clk);
        chk("min_rd_ack", 32'(m_ack), 1);
        chk("min_rd_dat", 32'(m_dat_o), 32'(init_m(3)));
        @(posedge clk);
        #1;
        m_start(1'b1, 32'hA, 16'hBEEF, 2'b01);
        @(negedge clk);
        chk("min_wr_we", 32'(m_wen), 0);
        chk("min_wr_be", 32'(m_be), 32'h2);
        @(negedge clk);
        chk("min_wr_ack", 32'(m_ack), 1);
        chk("min_hold", {30'd0, m_ce, m_wen}, 32'h1);
        @(posedge clk);
        #1;
        m_start(1'b0, 32'hA, 16'd0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        mexp = init_m(5);
        mexp[7:0] = 8'hEF;
        chk("min_readback_ack", 32'(m_ack), 1);
        chk("min_readback", 32'(m_dat_o), 32'(mexp));

        // randomized traffic against the reference model
        @(posedge clk);
        #1;
        for (int t = 0; t < 300; t++) begin
            k = int'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            if (k == 0) a = a | (32'd1 << $urandom_range(22, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (k == 1) s = 4'd0;
            if (k == 2) repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
            do_req(w, a, d, s, 1'b1, ac);
        end
        for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
        chk("drain", 32'(sbq.size()), 0);

        // reset in the middle of a write
        idle();
        do_req(1'b1, 32'h30, 32'h0BAD_0BAD, 4'hF, 1'b0, ac);
        @(negedge clk);
        chk("rstw_we_low", 32'(wen), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_pins", {29'd0, ce, oe, wen}, 32'h7);
        chk("rstw_be", 32'(be), 32'hF);
        chk("rstw_ack", 32'(ack), 0);
        chk("rstw_stall", 32'(stall), 0);
        chk("rstw_adr", 32'(sram_adr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_w(i);
        do_req(1'b0, 32'h10, 32'd0, 4'hF, 1'b1, ac);
        do_req(1'b0, 32'h8, 32'd0, 4'hF, 1'b1, ac);
        for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
        chk("drain_final", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
